if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage, directly upstream of the decode-stage controller.
- Owns the PC register, next-PC selection and the IF/ID pipeline register.
- Consumes the decode stage's 3-bit NPCOp, forwarded rs value and EPC, and talks to instruction memory over a req/rdy handshake with variable latency.
- Branches and jumps keep one architectural delay slot; interrupt entry (NPCOp 101) and ERET (NPCOp 100) squash the fetched slot.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_VECTOR, 32'h0000_4180, interrupt/exception entry address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard-unit freeze of the IF/ID register and PC.
- npc_op  in  3  000 seq, 001 branch, 010 j/jal, 011 jr/jalr, 100 eret, 101 interrupt.
- rs_fwd  in  32  forwarded rs of the D-stage instruction (jr/jalr target).
- epc  in  32  current CP0 EPC.
- imem_req  out  1  fetch request, held until imem_rdy.
- imem_addr  out  32  word address of the fetch (PC).
- imem_rdata  in  32  instruction; valid when imem_rdy=1.
- imem_rdy  in  1  response strobe, one cycle.
- if_busy  out  1  fetch outstanding; the pipeline freezes D and later stages while it is high.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pc8_d  out  32  pc_d+8, the link address.

Behaviour:
- Reset (sync):
  - pc=RESET_PC; state=REQ.
  - instr_d=0 (NOP), pc_d=0, pc8_d=8.
  - imem_req=1 in the first post-reset cycle.
- Target computation, from IF/ID contents:
  - 000: pc+4.
  - 001: pc_d+4+({{14{instr_d[15]}},instr_d[15:0],2'b00}).
  - 010: {pc_d[31:28] of pc_d+4, instr_d[25:0], 2'b00}.
  - 011: rs_fwd.
  - 100: epc.
  - 101: EXC_VECTOR.
  - 110/111: treated as 000.
  - All adds are modulo 2^32.
- FSM states:
  - REQ: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0; the fetched word sits in a hold register.
- An "advance" occurs when a word is available (REQ&imem_rdy, or HOLD) and stall=0. On advance:
  - pc <= target.
  - IF/ID <= {word, pc, pc+8}.
  - If npc_op is 100 or 101, IF/ID <= NOP with pc_d=pc; the delay slot is squashed.
  - Next state is REQ.
- REQ & imem_rdy & stall: capture imem_rdata into the hold register, go to HOLD; pc and IF/ID unchanged.
- HOLD & stall: remain; no new request.
- REQ & ~imem_rdy: if_busy=1; pc and IF/ID hold. npc_op is ignored until the word arrives; it stays stable because D is frozen.
- if_busy = (state==REQ) & ~imem_rdy; combinational.
- Redirect timing: a redirect is applied only on the advance cycle, so a branch in D always takes the F-stage word as its delay slot, whatever the memory latency.
- Simultaneous stall and imem_rdy: the word is never dropped (it goes to HOLD).
- Reset mid-fetch: an outstanding response is ignored; the FSM re-requests RESET_PC the next cycle. Memory must tolerate an abandoned request.
- imem_addr is stable while imem_req=1.

Optional Feature:
- Macro: IF_ALIGN_CHK_EN.
- With the macro defined:
  - A target with [1:0]!=0 is loaded into pc but not requested; imem_req=0.
  - The next advance loads IF/ID with a NOP and raises extra outputs exc_adel_d=1 and badvaddr_d=pc.
  - The flag clears on the next advance or on reset.
- Without the macro: target[1:0] is forced to 2'b00; no extra ports.

Decomposition:
- Shared package/header holds NPCOp encodings (NPC_SEQ, NPC_BR, NPC_J, NPC_JR, NPC_ERET, NPC_INT), RESET_PC, EXC_VECTOR and the NOP encoding.
- One sub-module: npc_calc, purely combinational target selection (npc_op, pc, pc_d, instr_d, rs_fwd, epc -> target).
- The FSM, PC and IF/ID register stay in the top module.

Test Plan:
- Zero-wait memory (imem_rdy tied 1), npc_op=000: after reset, pc_d sequence is 0x3000, 0x3004, 0x3008; pc8_d=pc_d+8.
- BEQ at 0x3010 with imm16=0x0004 and npc_op=001:
  - Delay slot 0x3014 enters IF/ID.
  - Next fetched PC is 0x3024.
- imem_rdy delayed by 3 cycles while D holds a jr with rs_fwd=0x3400:
  - if_busy=1 for 3 cycles.
  - The delay slot arrives, then the fetch goes to 0x3400.
- npc_op=101 with F at 0x3050: IF/ID gets NOP (instr_d=0), next fetch 0x4180; then npc_op=100 with epc=0x3050 resumes fetch at 0x3050 with the slot squashed.
- stall=1 asserted in the same cycle as imem_rdy (word 0x2408_0001):
  - FSM enters HOLD with imem_req=0.
  - 2 cycles later stall=0: instr_d=0x2408_0001 and no refetch occurs.
- Reset asserted while a fetch is outstanding: the late imem_rdy is ignored; imem_addr=0x3000 and IF/ID is NOP after reset. With IF_ALIGN_CHK_EN, jr to 0x3002 gives exc_adel_d=1 and badvaddr_d=0x3002.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: NPCOp encodings, reset/vector
// addresses, the NOP word and the fetch FSM state type.
package if_fetch_unit_pkg;

  localparam logic [2:0] NPC_SEQ  = 3'b000;
  localparam logic [2:0] NPC_BR   = 3'b001;
  localparam logic [2:0] NPC_J    = 3'b010;
  localparam logic [2:0] NPC_JR   = 3'b011;
  localparam logic [2:0] NPC_ERET = 3'b100;
  localparam logic [2:0] NPC_INT  = 3'b101;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] NOP        = 32'h0000_0000;

  typedef enum logic [1:0] {
    StReq,
    StHold,
    StMisal
  } fetch_state_e;

  // ERET and interrupt entry discard the word fetched behind them.
  function automatic logic is_squash(logic [2:0] op);
    return (op == NPC_ERET) || (op == NPC_INT);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory req/rdy bus between the fetch stage (master) and memory (slave).
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rdy;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_rdy
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_rdy
  );
endinterface

// File: rtl/if_fetch_unit_npc_calc.sv
// Combinational next-PC selection from the NPCOp issued by the D-stage instruction.
module if_fetch_unit_npc_calc
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] ExcVector = EXC_VECTOR
) (
  input  logic [2:0]  npc_op_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_d_i,
  input  logic [25:0] instr_d_i,
  input  logic [31:0] rs_fwd_i,
  input  logic [31:0] epc_i,
  output logic [31:0] target_o
);

  logic [31:0] pc_d_plus4;
  logic [31:0] br_offset;

  assign pc_d_plus4 = pc_d_i + 32'd4;
  assign br_offset  = {{14{instr_d_i[15]}}, instr_d_i[15:0], 2'b00};

  always_comb begin
    target_o = pc_i + 32'd4;
    case (npc_op_i)
      NPC_BR:   target_o = pc_d_plus4 + br_offset;
      NPC_J:    target_o = {pc_d_plus4[31:28], instr_d_i, 2'b00};
      NPC_JR:   target_o = rs_fwd_i;
      NPC_ERET: target_o = epc_i;
      NPC_INT:  target_o = ExcVector;
      default:  target_o = pc_i + 32'd4;
    endcase
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, req/rdy fetch FSM with hold register, and IF/ID register.
// Define IF_ALIGN_CHK_EN to trap misaligned targets instead of truncating them.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] ResetPc   = RESET_PC,
  parameter logic [31:0] ExcVector = EXC_VECTOR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic [2:0]            npc_op_i,
  input  logic [31:0]           rs_fwd_i,
  input  logic [31:0]           epc_i,
  if_fetch_unit_if.master       imem,
  output logic                  if_busy_o,
  output logic [31:0]           instr_d_o,
  output logic [31:0]           pc_d_o,
  output logic [31:0]           pc8_d_o
`ifdef IF_ALIGN_CHK_EN
  ,
  output logic                  exc_adel_d_o,
  output logic [31:0]           badvaddr_d_o
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q, hold_q, instr_q, pcd_q, pc8_q;
  logic [31:0]  target_raw, target, word;
  logic         avail, advance;

  if_fetch_unit_npc_calc #(
    .ExcVector (ExcVector)
  ) u_npc_calc (
    .npc_op_i  (npc_op_i),
    .pc_i      (pc_q),
    .pc_d_i    (pcd_q),
    .instr_d_i (instr_q[25:0]),
    .rs_fwd_i  (rs_fwd_i),
    .epc_i     (epc_i),
    .target_o  (target_raw)
  );

`ifdef IF_ALIGN_CHK_EN
  logic        misal;
  logic        exc_q;
  logic [31:0] bad_q;

  assign target       = target_raw;
  assign misal        = |target_raw[1:0];
  assign exc_adel_d_o = exc_q;
  assign badvaddr_d_o = bad_q;
`else
  assign target = target_raw & 32'hFFFF_FFFC;
`endif

  // Outside REQ a word (held, or a pending misaligned trap) is always ready.
  assign avail   = (state_q == StReq) ? imem.imem_rdy : 1'b1;
  assign advance = avail && !stall_i;
  assign word    = (state_q == StHold) ? hold_q : imem.imem_rdata;

  assign imem.imem_req  = (state_q == StReq);
  assign imem.imem_addr = pc_q;
  assign if_busy_o      = (state_q == StReq) && !imem.imem_rdy;
  assign instr_d_o      = instr_q;
  assign pc_d_o         = pcd_q;
  assign pc8_d_o        = pc8_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StReq;
      pc_q    <= ResetPc;
      hold_q  <= NOP;
      instr_q <= NOP;
      pcd_q   <= 32'd0;
      pc8_q   <= 32'd8;
`ifdef IF_ALIGN_CHK_EN
      exc_q   <= 1'b0;
      bad_q   <= 32'd0;
`endif
    end else if (advance) begin
      pc_q  <= target;
      pcd_q <= pc_q;
      pc8_q <= pc_q + 32'd8;
`ifdef IF_ALIGN_CHK_EN
      instr_q <= (is_squash(npc_op_i) || state_q == StMisal) ? NOP : word;
      exc_q   <= (state_q == StMisal);
      bad_q   <= pc_q;
      state_q <= misal ? StMisal : StReq;
`else
      instr_q <= is_squash(npc_op_i) ? NOP : word;
      state_q <= StReq;
`endif
    end else if (state_q == StReq && imem.imem_rdy) begin
      // Stalled while the response arrives: park the word so it is never lost.
      hold_q  <= imem.imem_rdata;
      state_q <= StHold;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit (builds with or without IF_ALIGN_CHK_EN).
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [2:0]  npc_op;
  logic [31:0] rs_fwd;
  logic [31:0] epc;
  logic        if_busy;
  logic [31:0] instr_d, pc_d, pc8_d;
`ifdef IF_ALIGN_CHK_EN
  logic        exc_adel_d;
  logic [31:0] badvaddr_d;
`endif

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stall_i   (stall),
    .npc_op_i  (npc_op),
    .rs_fwd_i  (rs_fwd),
    .epc_i     (epc),
    .imem      (bus),
    .if_busy_o (if_busy),
    .instr_d_o (instr_d),
    .pc_d_o    (pc_d),
    .pc8_d_o   (pc8_d)
`ifdef IF_ALIGN_CHK_EN
    ,
    .exc_adel_d_o (exc_adel_d),
    .badvaddr_d_o (badvaddr_d)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Program image: BEQ +4 at 0x3010, J 0x3100 at 0x3024, addiu-like filler elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_3010: return 32'h1000_0004;
      32'h0000_3024: return 32'h0800_0C40;
      default:       return {16'h2400, a[15:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Advance one clock, then let the memory model present the word at the new address.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.imem_rdata = mem_word(bus.imem_addr);
  endtask

  typedef struct {
    logic        stall;
    logic [2:0]  npc;
    logic [31:0] exp_pc_d;
    logic [31:0] exp_addr;
    logic        exp_req;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, NPC_SEQ, 32'h3000, 32'h3004, 1'b1};
    vecs[1]  = '{1'b0, NPC_SEQ, 32'h3004, 32'h3008, 1'b1};
    vecs[2]  = '{1'b0, NPC_SEQ, 32'h3008, 32'h300C, 1'b1};
    vecs[3]  = '{1'b0, NPC_SEQ, 32'h300C, 32'h3010, 1'b1};
    vecs[4]  = '{1'b0, NPC_SEQ, 32'h3010, 32'h3014, 1'b1};
    vecs[5]  = '{1'b0, NPC_BR,  32'h3014, 32'h3024, 1'b1};
    vecs[6]  = '{1'b0, NPC_SEQ, 32'h3024, 32'h3028, 1'b1};
    vecs[7]  = '{1'b0, NPC_J,   32'h3028, 32'h3100, 1'b1};
    vecs[8]  = '{1'b0, NPC_SEQ, 32'h3100, 32'h3104, 1'b1};
    vecs[9]  = '{1'b1, NPC_SEQ, 32'h3100, 32'h3104, 1'b0};
    vecs[10] = '{1'b1, NPC_SEQ, 32'h3100, 32'h3104, 1'b0};
    vecs[11] = '{1'b0, NPC_SEQ, 32'h3104, 32'h3108, 1'b1};

    reset = 1'b1;
    stall = 1'b0;
    npc_op = NPC_SEQ;
    rs_fwd = 32'd0;
    epc = 32'd0;
    bus.imem_rdy = 1'b0;
    bus.imem_rdata = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_instr_d", instr_d, 32'h0);
    chk("rst_pc_d", pc_d, 32'h0);
    chk("rst_pc8_d", pc8_d, 32'h8);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd1);
    chk("rst_addr", bus.imem_addr, 32'h3000);
    chk("rst_busy", {31'd0, if_busy}, 32'd1);
    bus.imem_rdy = 1'b1;
    #1;
    chk("rdy_busy", {31'd0, if_busy}, 32'd0);

    // Zero-wait memory: sequential, branch, jump and stall/hold rows.
    for (int i = 0; i < 12; i++) begin
      stall = vecs[i].stall;
      npc_op = vecs[i].npc;
      tick();
      chk($sformatf("vec%0d_pc_d", i), pc_d, vecs[i].exp_pc_d);
      chk($sformatf("vec%0d_pc8_d", i), pc8_d, vecs[i].exp_pc_d + 32'd8);
      chk($sformatf("vec%0d_instr", i), instr_d, mem_word(vecs[i].exp_pc_d));
      chk($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_req", i), {31'd0, bus.imem_req}, {31'd0, vecs[i].exp_req});
    end

    // jr in D with a 3-cycle memory latency: the delay slot still arrives first.
    stall = 1'b0;
    npc_op = NPC_JR;
    rs_fwd = 32'h3400;
    for (int i = 0; i < 3; i++) begin
      bus.imem_rdy = 1'b0;
      #1;
      chk($sformatf("lat%0d_busy", i), {31'd0, if_busy}, 32'd1);
      chk($sformatf("lat%0d_addr", i), bus.imem_addr, 32'h3108);
      tick();
      chk($sformatf("lat%0d_pc_d", i), pc_d, 32'h3104);
    end
    bus.imem_rdy = 1'b1;
    #1;
    chk("lat_rdy_busy", {31'd0, if_busy}, 32'd0);
    tick();
    chk("jr_slot_pc_d", pc_d, 32'h3108);
    chk("jr_slot_instr", instr_d, mem_word(32'h3108));
    chk("jr_target", bus.imem_addr, 32'h3400);
    npc_op = NPC_SEQ;
    tick();
    chk("jr_after_pc_d", pc_d, 32'h3400);

    // Steer F to 0x3050, then take an interrupt and return with ERET.
    npc_op = NPC_JR;
    rs_fwd = 32'h304C;
    tick();
    npc_op = NPC_SEQ;
    tick();
    chk("pre_int_addr", bus.imem_addr, 32'h3050);
    npc_op = NPC_INT;
    tick();
    chk("int_instr", instr_d, 32'h0);
    chk("int_pc_d", pc_d, 32'h3050);
    chk("int_vector", bus.imem_addr, 32'h4180);
    npc_op = NPC_SEQ;
    tick();
    chk("isr_pc_d", pc_d, 32'h4180);
    npc_op = NPC_ERET;
    epc = 32'h3050;
    tick();
    chk("eret_instr", instr_d, 32'h0);
    chk("eret_pc_d", pc_d, 32'h4184);
    chk("eret_addr", bus.imem_addr, 32'h3050);
    npc_op = NPC_SEQ;
    tick();
    chk("resume_pc_d", pc_d, 32'h3050);
    chk("resume_instr", instr_d, mem_word(32'h3050));

    // Stall coincides with the response: the word is parked, not refetched.
    stall = 1'b1;
    bus.imem_rdata = 32'h2408_0001;
    tick();
    chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
    chk("hold_pc_d", pc_d, 32'h3050);
    bus.imem_rdy = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_rdata = 32'hDEAD_BEEF;
    chk("hold2_req", {31'd0, bus.imem_req}, 32'd0);
    stall = 1'b0;
    #1;
    chk("hold_busy", {31'd0, if_busy}, 32'd0);
    tick();
    chk("hold_instr", instr_d, 32'h2408_0001);
    chk("hold_pc_d_out", pc_d, 32'h3054);
    chk("hold_next_addr", bus.imem_addr, 32'h3058);

    // Reset with a fetch outstanding; the late response lands during reset.
    bus.imem_rdy = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    bus.imem_rdy = 1'b1;
    bus.imem_rdata = 32'h0BAD_0BAD;
    tick();
    reset = 1'b0;
    bus.imem_rdy = 1'b0;
    #1;
    chk("mid_rst_addr", bus.imem_addr, 32'h3000);
    chk("mid_rst_instr", instr_d, 32'h0);
    chk("mid_rst_pc_d", pc_d, 32'h0);
    chk("mid_rst_busy", {31'd0, if_busy}, 32'd1);
    bus.imem_rdy = 1'b1;
    bus.imem_rdata = mem_word(32'h3000);
    tick();
    chk("post_rst_pc_d", pc_d, 32'h3000);
    chk("post_rst_instr", instr_d, mem_word(32'h3000));

    // jr to a misaligned target.
    npc_op = NPC_JR;
    rs_fwd = 32'h3002;
    tick();
`ifdef IF_ALIGN_CHK_EN
    chk("misal_req", {31'd0, bus.imem_req}, 32'd0);
    chk("misal_exc0", {31'd0, exc_adel_d}, 32'd0);
    npc_op = NPC_INT;
    tick();
    chk("misal_exc", {31'd0, exc_adel_d}, 32'd1);
    chk("misal_bad", badvaddr_d, 32'h3002);
    chk("misal_instr", instr_d, 32'h0);
    chk("misal_vec", bus.imem_addr, 32'h4180);
    npc_op = NPC_SEQ;
    tick();
    chk("misal_clear", {31'd0, exc_adel_d}, 32'd0);
`else
    chk("trunc_addr", bus.imem_addr, 32'h3000);
    chk("trunc_req", {31'd0, bus.imem_req}, 32'd1);
    npc_op = NPC_SEQ;
    tick();
    chk("trunc_pc_d", pc_d, 32'h3000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
